// File: rtl/lr_frame_pkg.sv
// Shared types and helpers for the left/right display link framer.
// Each framed byte carries the side in bit 7 and a 7-bit value in bits 6:0.
package lr_frame_pkg;

    localparam int VAL_W = 7;

    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_L = 3'd1,
        ACK_L  = 3'd2,
        DONE_L = 3'd3,
        LOAD_R = 3'd4,
        ACK_R  = 3'd5,
        DONE_R = 3'd6
    } lr_state_t;

    // Builds one link byte from a side flag and a value.
    function automatic logic [7:0] frame_byte(input logic side, input logic [VAL_W-1:0] val);
        return {side, val};
    endfunction

    // True for the states in which a byte is being offered to the UART.
    function automatic logic drives_send(input lr_state_t st);
        return (st == LOAD_L) || (st == ACK_L) || (st == LOAD_R) || (st == ACK_R);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: keeps the previous sample of each input bit and
// emits a one-cycle pulse when a bit goes from 0 to 1. The previous sample
// resets to 0, so an input held high through reset yields one pulse after
// reset is released.
module rise_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] i_level,
    output logic [WIDTH-1:0] o_pulse
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic r_prev;

            // Remember last cycle's level of this bit.
            always_ff @(posedge clk) begin
                if (srst) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= i_level[gi];
                end
            end

            assign o_pulse[gi] = i_level[gi] & ~r_prev;
        end
    endgenerate

endmodule

// File: rtl/lr_frame_tx.sv
// Transmit framer for the left/right display link. A request (rising edge
// of send, or the optional auto-timer) snapshots both values and pushes a
// left byte then a right byte through the UART's send/busy handshake.
// All outputs are registered and change on the same edge as the state.
module lr_frame_tx
    import lr_frame_pkg::*;
#(
    parameter int AUTO_PERIOD = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [6:0]       left_val,
    input  logic [6:0]       right_val,
    input  logic             send,
    output logic [7:0]       tx_data,
    output logic             tx_send,
    input  logic             tx_busy,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent
);

    lr_state_t        r_state;
    lr_state_t        w_state_next;

    logic             w_send_pulse;
    logic             w_timer_req;
    logic             w_req;
    logic             w_accept;
    logic             w_start_right;
    logic             w_frame_done;

    logic             r_pending;
    logic [VAL_W-1:0] r_right_snap;
    logic [7:0]       r_tx_data;
    logic             r_tx_send;
    logic             r_busy;
    logic [CNT_W-1:0] r_frames;

    rise_detect #(
        .WIDTH (1)
    ) u_send_rise (
        .clk     (clock),
        .srst    (reset),
        .i_level (send),
        .o_pulse (w_send_pulse)
    );

    // Auto-send timer: free-running, counting 0..AUTO_PERIOD-1; the cycle
    // in which it sits at the last count is the cycle it raises a request.
    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            localparam int              TMR_W    = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
            localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);

            logic [TMR_W-1:0] r_timer;

            // Wrap at the last count; keeps running while a frame is busy.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_timer <= '0;
                end else if (r_timer == TMR_LAST) begin
                    r_timer <= '0;
                end else begin
                    r_timer <= r_timer + TMR_W'(1);
                end
            end

            assign w_timer_req = (r_timer == TMR_LAST);
        end else begin : g_no_auto
            assign w_timer_req = 1'b0;
        end
    endgenerate

    // A send edge and a timer expiry in the same cycle merge into one request.
    assign w_req         = w_send_pulse | w_timer_req;
    assign w_accept      = (r_state == IDLE) && r_pending && !tx_busy;
    assign w_start_right = (r_state == DONE_L) && !tx_busy;
    assign w_frame_done  = (r_state == DONE_R) && !tx_busy;

    // One-deep request queue. A request landing while the flag is still set
    // (including the cycle it is being accepted) is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_pending <= 1'b0;
        end else if (w_req) begin
            r_pending <= 1'b1;
        end
    end

    // Next-state logic for the two-byte handshake sequence.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (r_pending && !tx_busy) w_state_next = LOAD_L;
            LOAD_L:  w_state_next = ACK_L;
            ACK_L:   if (tx_busy)  w_state_next = DONE_L;
            DONE_L:  if (!tx_busy) w_state_next = LOAD_R;
            LOAD_R:  w_state_next = ACK_R;
            ACK_R:   if (tx_busy)  w_state_next = DONE_R;
            DONE_R:  if (!tx_busy) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake outputs decoded from the state being entered, so tx_send
    // drops on the same edge that sees tx_busy high in an ACK state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_send <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_tx_send <= drives_send(w_state_next);
            r_busy    <= (w_state_next != IDLE);
        end
    end

    // Frame snapshot: the left byte register itself holds the left snapshot,
    // and the right value is parked until the left byte has been taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_data    <= 8'h00;
            r_right_snap <= '0;
        end else if (w_accept) begin
            r_tx_data    <= frame_byte(SIDE_LEFT, left_val);
            r_right_snap <= right_val;
        end else if (w_start_right) begin
            r_tx_data    <= frame_byte(SIDE_RIGHT, r_right_snap);
        end
    end

    // Completed-frame counter; only a frame that finishes its right byte counts.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_frames <= '0;
        end else if (w_frame_done) begin
            r_frames <= r_frames + CNT_W'(1);
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_send     = r_tx_send;
    assign busy        = r_busy;
    assign frames_sent = r_frames;

endmodule

// File: tb/tb_lr_frame_tx.sv
// Bench for lr_frame_tx. Two instances: dut0 (no auto-send, 2-bit frame
// counter) and dut1 (auto-send every 100 cycles, 8-bit counter). Each has
// its own UART stand-in with adjustable busy delay/hold. A transaction-level
// model predicts tx_send/tx_data/busy/frames_sent every cycle; directed
// scenarios add literal expectations on top.
`timescale 1ns/1ps
module tb_lr_frame_tx;

    localparam int NDUT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus driven by the bench
    logic       rst    [NDUT];
    logic       send_i [NDUT];
    logic [6:0] lv     [NDUT];
    logic [6:0] rv     [NDUT];
    logic       txb    [NDUT];

    // DUT outputs gathered into arrays
    logic [7:0] d0_txd, d1_txd;
    logic       d0_txs, d1_txs, d0_bsy, d1_bsy;
    logic [1:0] d0_fr;
    logic [7:0] d1_fr;
    logic [7:0] o_txd [NDUT];
    logic       o_txs [NDUT];
    logic       o_bsy [NDUT];
    logic [7:0] o_fr  [NDUT];

    always_comb begin
        o_txd[0] = d0_txd;
        o_txd[1] = d1_txd;
        o_txs[0] = d0_txs;
        o_txs[1] = d1_txs;
        o_bsy[0] = d0_bsy;
        o_bsy[1] = d1_bsy;
        o_fr[0]  = {6'd0, d0_fr};
        o_fr[1]  = d1_fr;
    end

    lr_frame_tx #(.AUTO_PERIOD(0), .CNT_W(2)) u_dut0 (
        .clock       (clk),
        .reset       (rst[0]),
        .left_val    (lv[0]),
        .right_val   (rv[0]),
        .send        (send_i[0]),
        .tx_data     (d0_txd),
        .tx_send     (d0_txs),
        .tx_busy     (txb[0]),
        .busy        (d0_bsy),
        .frames_sent (d0_fr)
    );

    lr_frame_tx #(.AUTO_PERIOD(100), .CNT_W(8)) u_dut1 (
        .clock       (clk),
        .reset       (rst[1]),
        .left_val    (lv[1]),
        .right_val   (rv[1]),
        .send        (send_i[1]),
        .tx_data     (d1_txd),
        .tx_send     (d1_txs),
        .tx_busy     (txb[1]),
        .busy        (d1_bsy),
        .frames_sent (d1_fr)
    );

    function automatic int auto_of(input int k);
        return (k == 0) ? 0 : 100;
    endfunction

    function automatic int cntw_of(input int k);
        return (k == 0) ? 2 : 8;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string what, input int budget);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out after %0d cycles", what, budget);
    endtask

    // Cycle counter (edges since time 0)
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // UART stand-in: raises busy after tx_send has been seen on u_delay
    // consecutive edges, holds it u_hold cycles, then drops it.
    int u_delay [NDUT] = '{1, 1};
    int u_hold  [NDUT] = '{20, 2};
    int u_wait  [NDUT];
    int u_cnt   [NDUT];

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            txb[k]    = 1'b0;
            u_wait[k] = 0;
            u_cnt[k]  = 0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (!txb[k]) begin
                    if (o_txs[k]) begin
                        u_wait[k] = u_wait[k] + 1;
                        if (u_wait[k] >= u_delay[k]) begin
                            txb[k]   <= 1'b1;
                            u_cnt[k]  = u_hold[k];
                            u_wait[k] = 0;
                        end
                    end else begin
                        u_wait[k] = 0;
                    end
                end else begin
                    if (u_cnt[k] <= 1) txb[k] <= 1'b0;
                    else u_cnt[k] = u_cnt[k] - 1;
                end
            end
        end
    end

    // ---------------- Behavioural model ----------------
    // A frame is two byte transfers. Each transfer offers a byte (tx_send
    // high) until the UART has been seen busy after at least one full cycle
    // of offering, then waits for the UART to go idle.
    bit         m_live     [NDUT];
    int         m_side     [NDUT];   // -1: no frame, 0: left byte, 1: right byte
    bit         m_offering [NDUT];
    int         m_age      [NDUT];   // edges the current offer has been up
    bit         m_pending  [NDUT];
    bit         m_sprev    [NDUT];
    int         m_timer    [NDUT];
    logic [6:0] m_snap_r   [NDUT];
    logic [7:0] m_data     [NDUT];
    int         m_frames   [NDUT];

    task automatic model_step(input int k);
        bit req;
        bit accept;
        if (rst[k]) begin
            m_live[k]     = 1'b1;
            m_side[k]     = -1;
            m_offering[k] = 1'b0;
            m_age[k]      = 0;
            m_pending[k]  = 1'b0;
            m_sprev[k]    = 1'b0;
            m_timer[k]    = 0;
            m_snap_r[k]   = 7'd0;
            m_data[k]     = 8'h00;
            m_frames[k]   = 0;
            return;
        end
        if (!m_live[k]) return;

        req = send_i[k] && !m_sprev[k];
        m_sprev[k] = send_i[k];
        if (auto_of(k) > 0) begin
            if (m_timer[k] == auto_of(k) - 1) begin
                req = 1'b1;
                m_timer[k] = 0;
            end else begin
                m_timer[k] = m_timer[k] + 1;
            end
        end

        accept = (m_side[k] < 0) && m_pending[k] && !txb[k];
        m_pending[k] = accept ? 1'b0 : (m_pending[k] | req);

        if (accept) begin
            m_side[k]     = 0;
            m_offering[k] = 1'b1;
            m_age[k]      = 0;
            m_data[k]     = {1'b0, lv[k]};
            m_snap_r[k]   = rv[k];
        end else if (m_side[k] >= 0) begin
            if (m_offering[k]) begin
                if (m_age[k] >= 1 && txb[k]) m_offering[k] = 1'b0;
                else m_age[k] = m_age[k] + 1;
            end else if (!txb[k]) begin
                if (m_side[k] == 0) begin
                    m_side[k]     = 1;
                    m_offering[k] = 1'b1;
                    m_age[k]      = 0;
                    m_data[k]     = {1'b1, m_snap_r[k]};
                end else begin
                    m_side[k]   = -1;
                    m_frames[k] = (m_frames[k] + 1) % (1 << cntw_of(k));
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) m_live[k] = 1'b0;
        forever begin
            @(posedge clk);
            for (int k = 0; k < NDUT; k++) model_step(k);
        end
    end

    // ---------------- Compare and monitors (falling edge) ----------------
    logic [7:0] blog0[$];       // bytes offered by dut0
    int         runs0[$];       // length of each tx_send high run on dut0
    logic       drop_busy0[$];  // tx_busy in the last cycle of each run
    int         starts1[$];     // cycle of each left-byte start on dut1
    logic       prev_s0 = 1'b0;
    logic       prev_s1 = 1'b0;
    int         run0 = 0;
    logic       busy_at0 = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (m_live[k]) begin
                    chk($sformatf("dut%0d tx_send", k), 32'(o_txs[k]), 32'(m_offering[k]));
                    chk($sformatf("dut%0d tx_data", k), 32'(o_txd[k]), 32'(m_data[k]));
                    chk($sformatf("dut%0d busy", k), 32'(o_bsy[k]), 32'(m_side[k] >= 0));
                    chk($sformatf("dut%0d frames_sent", k), 32'(o_fr[k]), 32'(m_frames[k]));
                end
            end
            if (o_txs[0] && !prev_s0) blog0.push_back(o_txd[0]);
            if (o_txs[0]) begin
                run0     = run0 + 1;
                busy_at0 = txb[0];
            end else if (prev_s0) begin
                runs0.push_back(run0);
                drop_busy0.push_back(busy_at0);
                run0 = 0;
            end
            prev_s0 = o_txs[0];
            if (o_txs[1] && !prev_s1 && !o_txd[1][7]) starts1.push_back(cyc);
            prev_s1 = o_txs[1];
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_busy(input int k, input logic want, input int budget, input string what);
        int n;
        n = 0;
        while (o_bsy[k] !== want && n < budget) begin
            step(1);
            n++;
        end
        if (o_bsy[k] !== want) timeout_fail(what, budget);
    endtask

    task automatic wait_txs(input int k, input logic want, input int budget, input string what);
        int n;
        n = 0;
        while (o_txs[k] !== want && n < budget) begin
            step(1);
            n++;
        end
        if (o_txs[k] !== want) timeout_fail(what, budget);
    endtask

    task automatic pulse_send(input int k);
        send_i[k] = 1'b1;
        step(1);
        send_i[k] = 1'b0;
        step(1);
    endtask

    // Stop a stuck run with a report rather than hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- Main sequence ----------------
    initial begin
        for (int k = 0; k < NDUT; k++) begin
            rst[k]    = 1'b1;
            send_i[k] = 1'b0;
            lv[k]     = 7'd0;
            rv[k]     = 7'd0;
        end
        send_i[0] = 1'b1;   // held through reset: must yield one frame
        step(3);

        // Reset values
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("reset dut%0d tx_send", k), 32'(o_txs[k]), 32'd0);
            chk($sformatf("reset dut%0d tx_data", k), 32'(o_txd[k]), 32'h00);
            chk($sformatf("reset dut%0d busy", k), 32'(o_bsy[k]), 32'd0);
            chk($sformatf("reset dut%0d frames", k), 32'(o_fr[k]), 32'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // send held high through reset -> exactly one frame
        wait_busy(0, 1'b1, 10, "held-send frame start");
        send_i[0] = 1'b0;
        wait_busy(0, 1'b0, 200, "held-send frame end");
        step(10);
        chk("held-send frames", 32'(o_fr[0]), 32'd1);
        rst[0] = 1'b1;
        step(1);
        rst[0] = 1'b0;
        step(2);

        // Basic frame and request latency
        blog0.delete();
        runs0.delete();
        lv[0] = 7'h15;
        rv[0] = 7'h2A;
        send_i[0] = 1'b1;
        step(1);
        chk("latency tx_send one edge after rise", 32'(o_txs[0]), 32'd0);
        send_i[0] = 1'b0;
        step(1);
        chk("latency tx_send two edges after rise", 32'(o_txs[0]), 32'd1);
        chk("latency first byte", 32'(o_txd[0]), 32'h15);
        wait_busy(0, 1'b0, 200, "basic frame end");
        chk("basic byte count", 32'(blog0.size()), 32'd2);
        if (blog0.size() >= 2) begin
            chk("basic left byte", 32'(blog0[0]), 32'h15);
            chk("basic right byte", 32'(blog0[1]), 32'hAA);
        end
        if (runs0.size() >= 1) chk("basic tx_send run", 32'(runs0[0]), 32'd2);
        chk("basic frames", 32'(o_fr[0]), 32'd1);

        // Snapshot: values change while the left byte is being acknowledged
        blog0.delete();
        pulse_send(0);
        wait_txs(0, 1'b1, 10, "snapshot left offer");
        step(1);
        lv[0] = 7'h7F;
        rv[0] = 7'h7F;
        wait_busy(0, 1'b0, 200, "snapshot frame end");
        pulse_send(0);
        wait_busy(0, 1'b1, 10, "snapshot second start");
        wait_busy(0, 1'b0, 200, "snapshot second end");
        chk("snapshot byte count", 32'(blog0.size()), 32'd4);
        if (blog0.size() >= 4) begin
            chk("snapshot right byte", 32'(blog0[1]), 32'hAA);
            chk("snapshot next left", 32'(blog0[2]), 32'h7F);
            chk("snapshot next right", 32'(blog0[3]), 32'hFF);
        end
        chk("snapshot frames", 32'(o_fr[0]), 32'd3);

        // Queueing: three edges during one frame give one extra frame
        blog0.delete();
        pulse_send(0);
        wait_busy(0, 1'b1, 10, "queue frame start");
        for (int i = 0; i < 3; i++) begin
            send_i[0] = 1'b1;
            step(1);
            send_i[0] = 1'b0;
            step(3);
        end
        wait_busy(0, 1'b0, 300, "queue first end");
        chk("frames wrap 3->0", 32'(o_fr[0]), 32'd0);
        wait_busy(0, 1'b1, 10, "queued frame start");
        wait_busy(0, 1'b0, 300, "queued frame end");
        step(100);
        chk("queue byte count", 32'(blog0.size()), 32'd4);
        chk("queue frames", 32'(o_fr[0]), 32'd1);
        chk("queue idle", 32'(o_bsy[0]), 32'd0);

        // Handshake with a slow UART: tx_send held until busy is seen
        u_delay[0] = 5;
        u_hold[0]  = 3;
        blog0.delete();
        runs0.delete();
        drop_busy0.delete();
        pulse_send(0);
        wait_busy(0, 1'b1, 10, "slow frame start");
        wait_busy(0, 1'b0, 200, "slow frame end");
        chk("slow byte count", 32'(blog0.size()), 32'd2);
        chk("slow run count", 32'(runs0.size()), 32'd2);
        if (runs0.size() >= 2) begin
            chk("slow left tx_send run", 32'(runs0[0]), 32'd6);
            chk("slow right tx_send run", 32'(runs0[1]), 32'd6);
            chk("slow busy seen before drop", 32'(drop_busy0[0]), 32'd1);
        end
        chk("slow frames", 32'(o_fr[0]), 32'd2);

        // Reset while waiting for the left byte to finish
        u_delay[0] = 1;
        u_hold[0]  = 20;
        blog0.delete();
        pulse_send(0);
        wait_txs(0, 1'b1, 10, "abort left offer");
        wait_txs(0, 1'b0, 20, "abort left acknowledged");
        rst[0] = 1'b1;
        step(1);
        rst[0] = 1'b0;
        chk("abort tx_send", 32'(o_txs[0]), 32'd0);
        chk("abort busy", 32'(o_bsy[0]), 32'd0);
        chk("abort frames", 32'(o_fr[0]), 32'd0);
        step(60);
        chk("abort byte count", 32'(blog0.size()), 32'd1);
        chk("abort frames later", 32'(o_fr[0]), 32'd0);

        // Auto-send period, with a send edge landing on the timer expiry
        starts1.delete();
        begin
            int n;
            n = 0;
            while (starts1.size() < 1 && n < 150) begin
                step(1);
                n++;
            end
            if (starts1.size() < 1) timeout_fail("auto first start", 150);
        end
        if (starts1.size() >= 1) begin
            while (cyc < starts1[0] + 98) step(1);
            send_i[1] = 1'b1;
            step(3);
            send_i[1] = 1'b0;
        end
        begin
            int n;
            n = 0;
            while (starts1.size() < 4 && n < 400) begin
                step(1);
                n++;
            end
            if (starts1.size() < 4) timeout_fail("auto four starts", 400);
        end
        if (starts1.size() >= 4) begin
            for (int i = 1; i < 4; i++)
                chk($sformatf("auto period %0d", i), 32'(starts1[i] - starts1[i-1]), 32'd100);
        end

        // Randomized traffic on both instances, checked by the model
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NDUT; k++) begin
                if ($urandom_range(0, 7) == 0) send_i[k] = ~send_i[k];
                if ($urandom_range(0, 3) == 0) lv[k] = 7'($urandom);
                if ($urandom_range(0, 3) == 0) rv[k] = 7'($urandom);
                if ($urandom_range(0, 49) == 0) begin
                    u_delay[k] = $urandom_range(1, 6);
                    u_hold[k]  = $urandom_range(1, 10);
                end
                rst[k] = ($urandom_range(0, 399) == 0);
            end
            step(1);
        end
        for (int k = 0; k < NDUT; k++) begin
            rst[k]    = 1'b0;
            send_i[k] = 1'b0;
        end
        step(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
